emi_gate_counter: RTL and testbench
===================================

# emi_gate_counter

Gated dual-channel event counter that produces the BCD measurement words shown by the on-screen display stage. It counts rising edges on two asynchronous pulse inputs over a fixed gate window of `clk_en` ticks. At each window end it latches the counts as 8-digit packed BCD (`rez1`, `rez2`), advances a 4-digit BCD window counter (`elapsed`) and restarts. Between windows it drives an 8-bit gate-progress bar (`mark`). Outputs connect directly to the display stage's `rez1`, `rez2`, `elapsed` and `mark` inputs.

## Interface
- `GATE_TICKS`, default 14000000: `clk_en` ticks per gate window; legal range 8..2^24; must be a multiple of 8.
- `clk`  in  1: system clock (14 MHz).
- `reset`  in  1: asynchronous, active-high reset.
- `clk_en`  in  1: gate time-base tick; advances the gate counter only.
- `pulse1`  in  1: channel 1 event input, asynchronous to `clk`.
- `pulse2`  in  1: channel 2 event input, asynchronous to `clk`.
- `rez1`  out  32: channel 1 result, 8 packed BCD digits, MSD in [31:28].
- `rez2`  out  32: channel 2 result, same format.
- `ovf1`  out  1: channel 1 saturated in the last completed window.
- `ovf2`  out  1: channel 2 saturated in the last completed window.
- `elapsed`  out  16: completed-window count, 4 packed BCD digits.
- `mark`  out  8: progress thermometer, filled from bit 7 downward.
- `done`  out  1: one-cycle strobe, high the cycle after new results are latched.

## Operation
- **Input path, per channel.** A 2-FF synchronizer feeds an edge register. An event is sync2 & ~edge_reg. Events are counted on every `clk`, independent of `clk_en`.
- **Channel counters.** 32-bit BCD, ripple-carry digit increment (digit 9 -> 0 plus carry).
  - At 99999999 a further event holds the value and sets the channel's internal sat flag.
- **Gate counter.** Binary, 0..GATE_TICKS-1. It increments only when `clk_en`=1.
  - gate_end = `clk_en` & (gate == GATE_TICKS-1). On gate_end the counter returns to 0.
- **On gate_end cycle, registered:**
  - `rez1` <= cnt1 and `rez2` <= cnt2, the values before this cycle's events.
  - `ovf1`/`ovf2` <= sat flags. Sat flags are then cleared.
  - cnt <= 1 if an event is present this cycle, else 0. A simultaneous event belongs to the new window.
  - `elapsed` <= BCD +1, wrapping 9999 -> 0000.
  - `done` <= 1. In all other cycles `done` <= 0.
- **Progress.** Let E = GATE_TICKS/8 and j = number of completed E-tick segments in the current window, 0..7.
  - `mark` = top j bits set, the rest 0. For example, j=3 gives 8'b11100000.
  - `mark` returns to 8'h00 on gate_end. 8'hFF never appears.
- **Outputs.** `rez`, `ovf`, `elapsed` and `done` hold between windows. Only gate_end changes them.
- **Reset, asynchronous.** All outputs clear to 0, as do channel counters, sat flags, the gate counter, synchronizers and edge registers.
  - A reset mid-window discards the partial counts.
  - After release, the first window is a full GATE_TICKS ticks.

## Timing
- Event latency: a `pulse` rising edge is counted in cnt 3 `clk` edges later (2 sync + 1 count).
- Minimum pulse high and low time is 2 `clk` periods. Faster trains are undercounted and are not flagged.
- Maximum count rate is one event per 2 clocks per channel.
- Results are visible 1 cycle after the gate_end cycle. `done` rises in that same cycle.
- `mark` updates 1 cycle after the `clk_en` that completes a segment.
- A `pulse` edge arriving 3 clocks or less before gate_end lands in the next window. This is the required behaviour.
- Gate period = GATE_TICKS × (clk_en period). With `clk_en` tied high at 14 MHz and the default parameter, the gate is 1.000 s.

## Test plan
- **Basic count.** GATE_TICKS=16, `clk_en`=1. Apply 37 clean pulses on `pulse1` and 5 on `pulse2`, all inside one window.
  - At `done`: `rez1`=32'h00000037, `rez2`=32'h00000005, `elapsed`=16'h0001, `ovf1`=`ovf2`=0.
- **BCD carry.** Force/preload cnt1 to 32'h00000999, then send 1 pulse.
  - At the next `done`: `rez1`=32'h00001000.
- **Saturation.** Preload cnt1 to 32'h99999998, then send 3 pulses.
  - At the next `done`: `rez1`=32'h99999999, `ovf1`=1.
  - The following window with 0 pulses gives `rez1`=0, `ovf1`=0.
- **Boundary and progress.** GATE_TICKS=16, `clk_en`=1. Place an event edge so its count falls in the gate_end cycle.
  - Old `rez` excludes the event; the next window's result includes it.
  - Check `mark`: 8'h00 at ticks 0-1, 8'h80 after tick 2, 8'hC0 after tick 4, 8'hFE after tick 14, 8'h00 after wrap.
- **Elapsed wrap and clk_en gating.** Preload elapsed to 16'h9999; the next `done` gives 16'h0000.
  - With `clk_en` at 1/4 duty, GATE_TICKS=16: `done` period is exactly 64 clocks.
- **Reset mid-window.** Assert `reset` for 1 cycle after 10 pulses.
  - All outputs are 0 immediately (async).
  - 4 pulses after release give `rez1`=32'h00000004 at the first `done`, 16 ticks after release.

Source files
------------

// File: rtl/emi_gate_counter.sv
// emi_gate_counter: gated dual-channel BCD event counter.
// Counts synchronized rising edges on two pulse inputs over a gate window of
// GATE_TICKS clk_en ticks. At each window end the counts are latched as packed
// BCD, a BCD window counter advances, and an 8-bit progress bar is cleared.
module emi_gate_counter #(
  parameter int unsigned GATE_TICKS = 14000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        pulse1,
  input  logic        pulse2,
  output logic [31:0] rez1,
  output logic [31:0] rez2,
  output logic        ovf1,
  output logic        ovf2,
  output logic [15:0] elapsed,
  output logic [7:0]  mark,
  output logic        done
);

  localparam int unsigned SEG_TICKS = GATE_TICKS / 8;
  localparam int GW = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
  localparam int SW = (SEG_TICKS > 1) ? $clog2(SEG_TICKS) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_TICKS - 1);
  localparam logic [SW-1:0] SEG_LAST  = SW'(SEG_TICKS - 1);
  localparam logic [31:0]   CNT_MAX   = 32'h99999999;

  // Packed BCD increment of 8 digits, ripple carry, wraps 99999999 -> 0.
  function automatic logic [31:0] bcd_inc(input logic [31:0] v);
    logic [31:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Channel next state {sat, cnt}. At window end the counter restarts and a
  // simultaneous event is credited to the new window.
  function automatic logic [32:0] chan_next(input logic [31:0] cnt,
                                            input logic        sat,
                                            input logic        ev,
                                            input logic        gend);
    logic [32:0] r;
    if (gend) begin
      r = {1'b0, 31'd0, ev};
    end else if (ev) begin
      if (cnt == CNT_MAX) begin
        r = {1'b1, cnt};
      end else begin
        r = {sat, bcd_inc(cnt)};
      end
    end else begin
      r = {sat, cnt};
    end
    return r;
  endfunction

  // Input path state
  logic [1:0]    sync1_q, sync2_q;
  logic          edge1_q, edge2_q;
  // Counting state
  logic [31:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic          sat1_q, sat1_d, sat2_q, sat2_d;
  logic [GW-1:0] gate_q, gate_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [2:0]    seg_idx_q, seg_idx_d;
  // Output registers
  logic [31:0]   rez1_q, rez1_d, rez2_q, rez2_d;
  logic          ovf1_q, ovf1_d, ovf2_q, ovf2_d;
  logic [15:0]   elapsed_q, elapsed_d;
  logic [7:0]    mark_q, mark_d;
  logic          done_q, done_d;
  logic [31:0]   elapsed_inc;

  logic          ev1, ev2, gate_end;

  assign ev1      = sync1_q[1] & ~edge1_q;
  assign ev2      = sync2_q[1] & ~edge2_q;
  assign gate_end = clk_en & (gate_q == GATE_LAST);

  assign elapsed_inc = bcd_inc({16'h0000, elapsed_q});

  // Next-state logic for counters, gate/progress tracking and result latches.
  always_comb begin
    {sat1_d, cnt1_d} = chan_next(cnt1_q, sat1_q, ev1, gate_end);
    {sat2_d, cnt2_d} = chan_next(cnt2_q, sat2_q, ev2, gate_end);

    gate_d    = gate_q;
    seg_d     = seg_q;
    seg_idx_d = seg_idx_q;
    if (clk_en) begin
      if (gate_end) begin
        gate_d    = {GW{1'b0}};
        seg_d     = {SW{1'b0}};
        seg_idx_d = 3'd0;
      end else if (seg_q == SEG_LAST) begin
        gate_d    = gate_q + GW'(1);
        seg_d     = {SW{1'b0}};
        seg_idx_d = seg_idx_q + 3'd1;
      end else begin
        gate_d    = gate_q + GW'(1);
        seg_d     = seg_q + SW'(1);
        seg_idx_d = seg_idx_q;
      end
    end else begin
      gate_d    = gate_q;
      seg_d     = seg_q;
      seg_idx_d = seg_idx_q;
    end

    // Thermometer from bit 7 down: top seg_idx bits set.
    mark_d = ~(8'hFF >> seg_idx_d);

    if (gate_end) begin
      rez1_d    = cnt1_q;
      rez2_d    = cnt2_q;
      ovf1_d    = sat1_q;
      ovf2_d    = sat2_q;
      elapsed_d = elapsed_inc[15:0];
      done_d    = 1'b1;
    end else begin
      rez1_d    = rez1_q;
      rez2_d    = rez2_q;
      ovf1_d    = ovf1_q;
      ovf2_d    = ovf2_q;
      elapsed_d = elapsed_q;
      done_d    = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      edge1_q   <= 1'b0;
      edge2_q   <= 1'b0;
      cnt1_q    <= 32'd0;
      cnt2_q    <= 32'd0;
      sat1_q    <= 1'b0;
      sat2_q    <= 1'b0;
      gate_q    <= {GW{1'b0}};
      seg_q     <= {SW{1'b0}};
      seg_idx_q <= 3'd0;
      rez1_q    <= 32'd0;
      rez2_q    <= 32'd0;
      ovf1_q    <= 1'b0;
      ovf2_q    <= 1'b0;
      elapsed_q <= 16'd0;
      mark_q    <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      sync1_q   <= {sync1_q[0], pulse1};
      sync2_q   <= {sync2_q[0], pulse2};
      edge1_q   <= sync1_q[1];
      edge2_q   <= sync2_q[1];
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      sat1_q    <= sat1_d;
      sat2_q    <= sat2_d;
      gate_q    <= gate_d;
      seg_q     <= seg_d;
      seg_idx_q <= seg_idx_d;
      rez1_q    <= rez1_d;
      rez2_q    <= rez2_d;
      ovf1_q    <= ovf1_d;
      ovf2_q    <= ovf2_d;
      elapsed_q <= elapsed_d;
      mark_q    <= mark_d;
      done_q    <= done_d;
    end
  end

  assign rez1    = rez1_q;
  assign rez2    = rez2_q;
  assign ovf1    = ovf1_q;
  assign ovf2    = ovf2_q;
  assign elapsed = elapsed_q;
  assign mark    = mark_q;
  assign done    = done_q;

endmodule

// File: tb/tb_emi_gate_counter.sv
// Directed testbench for emi_gate_counter with GATE_TICKS=16.
module tb_emi_gate_counter;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        pulse1;
  logic        pulse2;
  logic [31:0] rez1;
  logic [31:0] rez2;
  logic        ovf1;
  logic        ovf2;
  logic [15:0] elapsed;
  logic [7:0]  mark;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  emi_gate_counter #(.GATE_TICKS(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .pulse1  (pulse1),
    .pulse2  (pulse2),
    .rez1    (rez1),
    .rez2    (rez2),
    .ovf1    (ovf1),
    .ovf2    (ovf2),
    .elapsed (elapsed),
    .mark    (mark),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Clean pulses (2 high, 2 low); n1/n2 per channel, in lockstep. Ends at negedge.
  task automatic send_pulses(input int n1, input int n2);
    int n;
    n = (n1 > n2) ? n1 : n2;
    for (int i = 0; i < n; i++) begin
      pulse1 = (i < n1);
      pulse2 = (i < n2);
      @(negedge clk);
      @(negedge clk);
      pulse1 = 1'b0;
      pulse2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  // Hold clk_en high until done is seen; returns ticks used. Ends at negedge.
  task automatic run_window(output int ticks);
    ticks  = 0;
    clk_en = 1'b1;
    while (1) begin
      @(posedge clk);
      ticks++;
      @(negedge clk);
      if (done) break;
      if (ticks >= 100) begin
        check("done_timeout", {31'd0, done}, 32'd1);
        break;
      end
    end
    clk_en = 1'b0;
  endtask

  initial begin
    int ticks;
    int t_first;
    int t_second;
    int seen;

    reset  = 1'b1;
    clk_en = 1'b0;
    pulse1 = 1'b0;
    pulse2 = 1'b0;
    #12;
    check("rst_rez1", rez1, 32'h0);
    check("rst_rez2", rez2, 32'h0);
    check("rst_elapsed", {16'h0, elapsed}, 32'h0);
    check("rst_mark", {24'h0, mark}, 32'h0);
    check("rst_done_ovf", {29'd0, done, ovf1, ovf2}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic count: 37 on ch1, 5 on ch2, gate frozen while pulsing.
    send_pulses(37, 5);
    run_window(ticks);
    check("basic_ticks", ticks, 32'd16);
    check("basic_rez1", rez1, 32'h00000037);
    check("basic_rez2", rez2, 32'h00000005);
    check("basic_elapsed", {16'h0, elapsed}, 32'h00000001);
    check("basic_ovf", {30'd0, ovf1, ovf2}, 32'h0);
    @(negedge clk);
    check("done_strobe", {31'd0, done}, 32'd0);
    check("rez1_hold", rez1, 32'h00000037);

    // Boundary and progress: pulses rising before edges 1, 6 and 14.
    check("mark_t0", {24'h0, mark}, 32'h00);
    for (int k = 0; k < 16; k++) begin
      clk_en = 1'b1;
      pulse1 = (k == 0 || k == 1 || k == 5 || k == 6 || k == 13 || k == 14);
      @(posedge clk);
      @(negedge clk);
      case (k + 1)
        1:  check("mark_t1", {24'h0, mark}, 32'h00);
        2:  check("mark_t2", {24'h0, mark}, 32'h80);
        4:  check("mark_t4", {24'h0, mark}, 32'hC0);
        14: check("mark_t14", {24'h0, mark}, 32'hFE);
        16: begin
          check("bnd_done", {31'd0, done}, 32'd1);
          check("mark_wrap", {24'h0, mark}, 32'h00);
          check("bnd_rez1_old", rez1, 32'h00000002);
        end
        default: ;
      endcase
    end
    pulse1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("bnd_done2", {31'd0, done}, 32'd1);
    check("bnd_rez1_new", rez1, 32'h00000001);
    check("bnd_elapsed", {16'h0, elapsed}, 32'h00000003);
    clk_en = 1'b0;
    @(negedge clk);

    // BCD carry: 999 + 1.
    force dut.cnt1_q = 32'h00000999;
    @(negedge clk);
    release dut.cnt1_q;
    send_pulses(1, 0);
    run_window(ticks);
    check("carry_rez1", rez1, 32'h00001000);

    // Saturation: 99999998 + 3.
    force dut.cnt1_q = 32'h99999998;
    @(negedge clk);
    release dut.cnt1_q;
    send_pulses(3, 0);
    run_window(ticks);
    check("sat_rez1", rez1, 32'h99999999);
    check("sat_ovf1", {31'd0, ovf1}, 32'd1);
    check("sat_ovf2", {31'd0, ovf2}, 32'd0);
    run_window(ticks);
    check("sat_clr_rez1", rez1, 32'h0);
    check("sat_clr_ovf1", {31'd0, ovf1}, 32'd0);
    check("sat_elapsed", {16'h0, elapsed}, 32'h00000006);

    // Elapsed wrap 9999 -> 0000.
    force dut.elapsed_q = 16'h9999;
    @(negedge clk);
    release dut.elapsed_q;
    run_window(ticks);
    check("elapsed_wrap", {16'h0, elapsed}, 32'h00000000);

    // clk_en at 1/4 duty: done period must be 64 clocks.
    seen     = 0;
    t_first  = 0;
    t_second = 0;
    for (int c = 0; c < 300; c++) begin
      clk_en = ((c % 4) == 0);
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (seen == 0) t_first = c;
        else t_second = c;
        seen++;
      end
      if (seen >= 2) break;
    end
    clk_en = 1'b0;
    check("duty_done_count", seen, 32'd2);
    check("duty_period", t_second - t_first, 32'd64);
    check("duty_elapsed", {16'h0, elapsed}, 32'h00000002);

    // Reset mid-window.
    send_pulses(6, 2);
    run_window(ticks);
    check("pre_rst_rez1", rez1, 32'h00000006);
    check("pre_rst_rez2", rez2, 32'h00000002);
    clk_en = 1'b1;
    repeat (5) @(negedge clk);
    clk_en = 1'b0;
    check("pre_rst_mark", {24'h0, mark}, 32'hC0);
    send_pulses(10, 0);
    reset = 1'b1;
    #1;
    check("async_rez1", rez1, 32'h0);
    check("async_rez2", rez2, 32'h0);
    check("async_elapsed", {16'h0, elapsed}, 32'h0);
    check("async_mark", {24'h0, mark}, 32'h0);
    check("async_done_ovf", {29'd0, done, ovf1, ovf2}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_pulses(4, 0);
    run_window(ticks);
    check("post_rst_ticks", ticks, 32'd16);
    check("post_rst_rez1", rez1, 32'h00000004);
    check("post_rst_elapsed", {16'h0, elapsed}, 32'h00000001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
